// File: rtl/pe_pkg.sv
// Shared definitions for the PE operand feeders: default data width,
// feeder sequencing states and the operand bundle seen by one PE.
package pe_pkg;

    localparam int PE_DATA_W = 8;

    // Sequencing phases of a feeder: collect, load weight, replay A, drain, report.
    typedef enum logic [2:0] {
        FILL   = 3'd0,
        LOAD_B = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    // Operand set presented to one PE input port group.
    typedef struct packed {
        logic [PE_DATA_W-1:0] a;
        logic [PE_DATA_W-1:0] b;
        logic                 b_en;
        logic [PE_DATA_W-1:0] psum;
    } pe_operand_t;

    // True while a feeder owns the PE (weight load, stream or drain).
    function automatic logic is_busy_state(input feeder_state_t s);
        return (s == LOAD_B) || (s == STREAM) || (s == FLUSH);
    endfunction

endpackage

// File: rtl/pe_operand_feeder_if.sv
// Bundle of the feeder's upstream A stream, weight load port and PE-side
// operand outputs. PE_FEEDER_STALL_EN adds the pe_stall input.
interface pe_operand_feeder_if
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              w_valid;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_psum;
    logic [DATA_W-1:0] pe_a;
    logic [DATA_W-1:0] pe_b;
    logic              pe_b_en;
    logic [DATA_W-1:0] pe_psum;
    logic              busy;
    logic              done;
`ifdef PE_FEEDER_STALL_EN
    logic              pe_stall;
`endif

    // Feeder side.
    modport slave (
`ifdef PE_FEEDER_STALL_EN
        input  pe_stall,
`endif
        input  s_valid, s_data, s_last, w_valid, w_b, w_psum,
        output s_ready, pe_a, pe_b, pe_b_en, pe_psum, busy, done
    );

    // Memory / PE-row side that drives the feeder.
    modport master (
`ifdef PE_FEEDER_STALL_EN
        output pe_stall,
`endif
        output s_valid, s_data, s_last, w_valid, w_b, w_psum,
        input  s_ready, pe_a, pe_b, pe_b_en, pe_psum, busy, done
    );

endinterface

// File: rtl/pe_feeder_buf.sv
// A-operand burst store: DEPTH x DATA_W register file, filled in order
// from index 0, with a fill count and a combinational read port.
module pe_feeder_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_clr,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [DATA_W-1:0]          o_rd_data
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic [DEPTH-1:0]  w_we;

    assign w_full = (r_count == DEPTH_C);

    // One write strobe per entry: the slot addressed by the current count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = i_wr_en && !w_full && (r_count[AW-1:0] == AW'(gi));
        end
    endgenerate

    // Storage is never cleared; entries at or above the count are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_we[i]) begin
                r_mem[i] <= i_wr_data;
            end
        end
    end

    // Fill count: cleared at burst end or reset, saturates at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_wr_en && !w_full) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/pe_operand_feeder.sv
// Operand feeder for a single PE: buffers an A burst plus one B weight and
// partial-sum seed, then replays weight load, A stream and a zero flush.
// Optional macro PE_FEEDER_STALL_EN adds pe_stall, which freezes the replay.
module pe_operand_feeder
    import pe_pkg::*;
#(
    parameter int DATA_W    = PE_DATA_W,
    parameter int DEPTH     = 8,
    parameter int FLUSH_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    pe_operand_feeder_if.slave ifc
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int FL_W  = $clog2(FLUSH_CYC) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLUSH_CYC - 1);

    feeder_state_t     r_state, w_state_next;
    logic              r_got_last, w_got_last_next;
    logic              r_w_ok, w_w_ok_next;
    logic [DATA_W-1:0] r_w_b, w_w_b_next;
    logic [DATA_W-1:0] r_w_psum, w_w_psum_next;
    logic [CNT_W-1:0]  r_idx, w_idx_next;
    logic [FL_W-1:0]   r_fl, w_fl_next;

    logic [DATA_W-1:0] r_pe_a, w_pe_a_next;
    logic [DATA_W-1:0] r_pe_b, w_pe_b_next;
    logic              r_pe_b_en, w_pe_b_en_next;
    logic [DATA_W-1:0] r_pe_psum, w_pe_psum_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_s_ready, w_s_ready_next;

    logic [CNT_W-1:0]  w_count, w_count_next;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_accept;
    logic              w_clr;
    logic              w_seq_active;
    logic              w_stall;

    assign w_accept     = ifc.s_valid && r_s_ready;
    assign w_clr        = (r_state == DONE);
    assign w_seq_active = is_busy_state(r_state);

`ifdef PE_FEEDER_STALL_EN
    assign w_stall = ifc.pe_stall && w_seq_active;
`else
    assign w_stall = 1'b0;
`endif

    pe_feeder_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_accept),
        .i_wr_data (ifc.s_data),
        .i_clr     (w_clr),
        .i_rd_idx  (r_idx[AW-1:0]),
        .o_count   (w_count),
        .o_rd_data (w_rd_data)
    );

    // Next state, burst bookkeeping and next values of every output register.
    always_comb begin
        w_state_next    = r_state;
        w_got_last_next = r_got_last;
        w_w_ok_next     = r_w_ok;
        w_w_b_next      = r_w_b;
        w_w_psum_next   = r_w_psum;
        w_idx_next      = r_idx;
        w_fl_next       = r_fl;
        w_count_next    = w_count;
        w_pe_a_next     = '0;
        w_pe_b_next     = r_pe_b;
        w_pe_b_en_next  = 1'b0;
        w_pe_psum_next  = '0;
        w_busy_next     = w_seq_active;
        w_done_next     = (r_state == DONE);

        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_count_next = w_count + 1'b1;
                    // Filling the last slot closes the burst even without s_last.
                    if (ifc.s_last || (w_count == DEPTH_C - 1'b1)) begin
                        w_got_last_next = 1'b1;
                    end
                end
                if (ifc.w_valid) begin
                    w_w_b_next    = ifc.w_b;
                    w_w_psum_next = ifc.w_psum;
                    w_w_ok_next   = 1'b1;
                end
                // Flags are registered, so a burst completed this cycle exits next edge.
                if (r_got_last && r_w_ok) begin
                    w_state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                w_pe_b_next    = r_w_b;
                w_pe_b_en_next = 1'b1;
                w_idx_next     = '0;
                w_state_next   = STREAM;
            end
            STREAM: begin
                w_pe_a_next    = w_rd_data;
                w_pe_b_next    = r_w_b;
                w_pe_psum_next = r_w_psum;
                w_idx_next     = r_idx + 1'b1;
                w_fl_next      = '0;
                if (r_idx == w_count - 1'b1) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                w_fl_next = r_fl + 1'b1;
                if (r_fl == FL_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_count_next    = '0;
                w_got_last_next = 1'b0;
                w_w_ok_next     = 1'b0;
                w_state_next    = FILL;
            end
            default: begin
                w_state_next = FILL;
            end
        endcase

        // A stall holds the sequence position and the PE operands, but never
        // re-fires the B latch.
        if (w_stall) begin
            w_state_next   = r_state;
            w_idx_next     = r_idx;
            w_fl_next      = r_fl;
            w_pe_a_next    = r_pe_a;
            w_pe_b_next    = r_pe_b;
            w_pe_psum_next = r_pe_psum;
            w_pe_b_en_next = 1'b0;
        end

        // Registered ready must reflect the state the next cycle will be in.
        w_s_ready_next = (w_state_next == FILL) && !w_got_last_next &&
                         (w_count_next < DEPTH_C);
    end

    // State, burst flags, weight/seed and sequence counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_got_last <= 1'b0;
            r_w_ok     <= 1'b0;
            r_w_b      <= '0;
            r_w_psum   <= '0;
            r_idx      <= '0;
            r_fl       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_got_last <= w_got_last_next;
            r_w_ok     <= w_w_ok_next;
            r_w_b      <= w_w_b_next;
            r_w_psum   <= w_w_psum_next;
            r_idx      <= w_idx_next;
            r_fl       <= w_fl_next;
        end
    end

    // Output registers; reset drops every PE operand to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pe_a    <= '0;
            r_pe_b    <= '0;
            r_pe_b_en <= 1'b0;
            r_pe_psum <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_s_ready <= 1'b0;
        end else begin
            r_pe_a    <= w_pe_a_next;
            r_pe_b    <= w_pe_b_next;
            r_pe_b_en <= w_pe_b_en_next;
            r_pe_psum <= w_pe_psum_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_s_ready <= w_s_ready_next;
        end
    end

    assign ifc.pe_a    = r_pe_a;
    assign ifc.pe_b    = r_pe_b;
    assign ifc.pe_b_en = r_pe_b_en;
    assign ifc.pe_psum = r_pe_psum;
    assign ifc.busy    = r_busy;
    assign ifc.done    = r_done;
    assign ifc.s_ready = r_s_ready;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Bench for pe_operand_feeder: frame-queue reference model compared every
// cycle, plus directed bursts with literal expectations.
module tb_pe_operand_feeder;
    import pe_pkg::*;

    localparam int DW        = 8;
    localparam int DEPTH     = 8;
    localparam int FLUSH_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_operand_feeder_if #(.DATA_W(DW)) ifc();

    pe_operand_feeder #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] psum;
        logic          b_en;
        logic          busy;
        logic          done;
    } frame_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    // Reference model state: what the PE must see after each clock edge.
    frame_t        fq[$];
    frame_t        disp;
    logic [DW-1:0] m_buf[$];
    logic          m_got_last, m_w_ok, m_start, m_stall;
    logic [DW-1:0] m_w_b, m_w_psum;
    logic          exp_s_ready;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        fq.delete();
        m_buf.delete();
        m_got_last  = 1'b0;
        m_w_ok      = 1'b0;
        m_w_b       = '0;
        m_w_psum    = '0;
        disp        = '{a: '0, b: '0, psum: '0, b_en: 1'b0, busy: 1'b0, done: 1'b0};
        exp_s_ready = 1'b0;
    endfunction

    // Whole replay of a finished burst: weight load, A words, zero drain, done.
    function automatic void build_frames();
        fq.push_back('{a: '0, b: m_w_b, psum: '0, b_en: 1'b1, busy: 1'b1, done: 1'b0});
        foreach (m_buf[i])
            fq.push_back('{a: m_buf[i], b: m_w_b, psum: m_w_psum, b_en: 1'b0, busy: 1'b1, done: 1'b0});
        for (int i = 0; i < FLUSH_CYC; i++)
            fq.push_back('{a: '0, b: m_w_b, psum: '0, b_en: 1'b0, busy: 1'b1, done: 1'b0});
        fq.push_back('{a: '0, b: m_w_b, psum: '0, b_en: 1'b0, busy: 1'b0, done: 1'b1});
    endfunction

    // Model step: either play the next frame of a replay or collect a burst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
`ifdef PE_FEEDER_STALL_EN
            m_stall = ifc.pe_stall;
`else
            m_stall = 1'b0;
`endif
            if (fq.size() != 0) begin
                if (m_stall && !fq[0].done) begin
                    disp.b_en = 1'b0;
                    disp.busy = 1'b1;
                    disp.done = 1'b0;
                end else begin
                    disp = fq.pop_front();
                    if (disp.done) begin
                        m_buf.delete();
                        m_got_last = 1'b0;
                        m_w_ok     = 1'b0;
                    end
                end
            end else begin
                m_start = m_got_last && m_w_ok;
                if (ifc.s_valid && exp_s_ready) begin
                    m_buf.push_back(ifc.s_data);
                    if (ifc.s_last || m_buf.size() == DEPTH) m_got_last = 1'b1;
                end
                if (ifc.w_valid) begin
                    m_w_b    = ifc.w_b;
                    m_w_psum = ifc.w_psum;
                    m_w_ok   = 1'b1;
                end
                disp.a    = '0;
                disp.psum = '0;
                disp.b_en = 1'b0;
                disp.busy = 1'b0;
                disp.done = 1'b0;
                if (m_start) build_frames();
            end
            exp_s_ready = (fq.size() == 0) && !m_got_last && (m_buf.size() < DEPTH);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_pe_a",    ifc.pe_a,    disp.a);
            check("cyc_pe_b",    ifc.pe_b,    disp.b);
            check("cyc_pe_psum", ifc.pe_psum, disp.psum);
            check("cyc_pe_b_en", ifc.pe_b_en, disp.b_en);
            check("cyc_busy",    ifc.busy,    disp.busy);
            check("cyc_done",    ifc.done,    disp.done);
            check("cyc_s_ready", ifc.s_ready, exp_s_ready);
        end
    end

    task automatic load_w(input int b, input int p);
        ifc.w_valid = 1'b1;
        ifc.w_b     = DW'(b);
        ifc.w_psum  = DW'(p);
        @(negedge clk);
        ifc.w_valid = 1'b0;
    endtask

    task automatic send(input int d, input logic last);
        logic ok;
        ok = 1'b0;
        ifc.s_valid = 1'b1;
        ifc.s_data  = DW'(d);
        ifc.s_last  = last;
        for (int i = 0; i < 40; i++) begin
            ok = ifc.s_ready;
            @(negedge clk);
            if (ok) break;
        end
        if (!ok) check("send_timeout", 0, 1);
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
    endtask

    task automatic wait_b_en(input string tag);
        int k;
        for (k = 0; k < 20; k++) begin
            if (ifc.pe_b_en) break;
            @(negedge clk);
        end
        check({tag, "_b_en_latency"}, k, 2);
    endtask

    task automatic expect_seq(input string tag, input int b, input int psum,
                              input logic [DW-1:0] a_q[$]);
        check({tag, "_load_b"},    ifc.pe_b,    b);
        check({tag, "_load_b_en"}, ifc.pe_b_en, 1);
        check({tag, "_ready_low"}, ifc.s_ready, 0);
        foreach (a_q[i]) begin
            @(negedge clk);
            check({tag, "_a"},    ifc.pe_a,    a_q[i]);
            check({tag, "_psum"}, ifc.pe_psum, psum);
            check({tag, "_b"},    ifc.pe_b,    b);
        end
        for (int i = 0; i < FLUSH_CYC; i++) begin
            @(negedge clk);
            check({tag, "_flush_a"},    ifc.pe_a, 0);
            check({tag, "_flush_busy"}, ifc.busy, 1);
        end
        @(negedge clk);
        check({tag, "_done"}, ifc.done, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, ifc.done,    0);
        check({tag, "_ready_back"}, ifc.s_ready, 1);
        $display("burst %s: %0d operands replayed, w_b=%0d psum=%0d", tag, a_q.size(), b, psum);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        ifc.s_last  = 1'b0;
        ifc.w_valid = 1'b0;
        ifc.w_b     = '0;
        ifc.w_psum  = '0;
`ifdef PE_FEEDER_STALL_EN
        ifc.pe_stall = 1'b0;
`endif
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_s_ready", ifc.s_ready, 0);
        check("rst_pe_a",    ifc.pe_a,    0);
        check("rst_pe_b_en", ifc.pe_b_en, 0);
        check("rst_busy",    ifc.busy,    0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ifc.s_ready, 1);

        // Burst 1,2 with weight/seed 3.
        load_w(3, 3);
        send(1, 1'b0);
        send(2, 1'b1);
        wait_b_en("basic");
        q = '{8'd1, 8'd2};
        expect_seq("basic", 3, 3, q);

        // Weight arrives well after the burst closes.
        send(1, 1'b0);
        send(2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("late_w_no_b_en", ifc.pe_b_en, 0);
            check("late_w_ready",   ifc.s_ready, 0);
            @(negedge clk);
        end
        load_w(3, 3);
        wait_b_en("late_w");
        expect_seq("late_w", 3, 3, q);

        // Full buffer without s_last.
        load_w(2, 10);
        for (int i = 0; i < DEPTH; i++) send(11 + i, 1'b0);
        check("full_ready_drop", ifc.s_ready, 0);
        wait_b_en("full");
        q = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
        expect_seq("full", 2, 10, q);

        // Gaps in upstream valid.
        load_w(1, 0);
        send(5, 1'b0);
        @(negedge clk);
        send(7, 1'b1);
        wait_b_en("gappy");
        q = '{8'd5, 8'd7};
        expect_seq("gappy", 1, 0, q);

        // Reset in the middle of a stream.
        load_w(9, 4);
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b1);
        wait_b_en("abort");
        @(negedge clk);
        check("abort_a_before", ifc.pe_a, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_pe_a",    ifc.pe_a,    0);
        check("abort_pe_b",    ifc.pe_b,    0);
        check("abort_pe_psum", ifc.pe_psum, 0);
        check("abort_busy",    ifc.busy,    0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", ifc.s_ready, 1);
        load_w(6, 2);
        send(4, 1'b1);
        wait_b_en("post_abort");
        q = '{8'd4};
        expect_seq("post_abort", 6, 2, q);

`ifdef PE_FEEDER_STALL_EN
        // Three-cycle stall while pe_a shows 2.
        load_w(2, 1);
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b1);
        wait_b_en("stall");
        @(negedge clk);
        check("stall_a1", ifc.pe_a, 1);
        @(negedge clk);
        check("stall_a2", ifc.pe_a, 2);
        ifc.pe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold_a",    ifc.pe_a,    2);
            check("stall_hold_b_en", ifc.pe_b_en, 0);
        end
        ifc.pe_stall = 1'b0;
        @(negedge clk);
        check("stall_a3", ifc.pe_a, 3);
        repeat (FLUSH_CYC) @(negedge clk);
        @(negedge clk);
        check("stall_done", ifc.done, 1);
        $display("burst stall: resumed after 3 held cycles");
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Transmit-side driver for the single processing element's operand interface (in_a, in_b, b_en, p_sum).
- Buffers a burst of A operands from an upstream valid/ready stream and holds one B weight plus a partial-sum seed.
- Replays them to one PE as a framed sequence: weight load, A stream, zero flush.
- Sits between the activation/weight memories and the PE row.

Parameters:
- DATA_W, 8, width of A, B and partial sum.
- DEPTH, 8, max A words per burst; power of two, ≥2.
- FLUSH_CYC, 2, zero-A cycles after the stream so PE pipeline drains.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream A word valid.
- s_ready  out  1  feeder can accept A word.
- s_data  in  DATA_W  A operand.
- s_last  in  1  final A word of burst.
- w_valid  in  1  load weight/seed registers this cycle.
- w_b  in  DATA_W  B weight.
- w_psum  in  DATA_W  partial-sum seed.
- pe_a  out  DATA_W  to PE in_a.
- pe_b  out  DATA_W  to PE in_b.
- pe_b_en  out  1  to PE b_en; B latch enable.
- pe_psum  out  DATA_W  to PE p_sum.
- busy  out  1  high in LOAD_B/STREAM/FLUSH.
- done  out  1  one-cycle pulse after last flush cycle.

Behaviour:
- Reset (async, immediate): state FILL, buffer count 0, w_ok=0. Outputs: pe_a=0, pe_b=0, pe_b_en=0, pe_psum=0, busy=0, done=0, s_ready=0 until first edge after release.
- All pe_* outputs are registered.
- FILL:
  - s_ready = (count<DEPTH) && !got_last.
  - Handshake completes on s_valid&&s_ready; word is written at index count, count increments.
  - s_last on an accepted beat sets got_last. Reaching count==DEPTH also sets got_last; a later s_last is ignored.
  - w_valid loads w_b/w_psum and sets w_ok. This is accepted only in FILL; it is ignored elsewhere.
  - Leaves FILL to LOAD_B on the edge where got_last && w_ok. If both become true in the same cycle, LOAD_B is entered on the next edge.
- LOAD_B: 1 cycle. Drives pe_b=w_b, pe_b_en=1, pe_a=0, pe_psum=0, then moves to STREAM.
- STREAM: count cycles, index 0..count-1.
  - pe_a=buf[i], pe_psum=w_psum, pe_b_en=0, pe_b holds w_b.
  - s_ready=0.
- FLUSH: FLUSH_CYC cycles with pe_a=0, pe_psum=0, pe_b_en=0.
- DONE: 1 cycle, done=1. Clears count, got_last and w_ok, then returns to FILL.
- Outputs lag the state by one cycle (registered): first pe_b_en=1 appears on the edge after the FILL exit edge.
- Zero-length burst is impossible: s_last is only seen on an accepted word, so count≥1.
- Counters are sized $clog2(DEPTH)+1 and do not wrap. The index counter resets to 0 on STREAM entry.
- rst asserted mid-burst discards buffer and weight; the PE sees all-zero operands from the reset instant.

Optional Feature:
- Macro: PE_FEEDER_STALL_EN.
- With the macro: adds input pe_stall (1 bit).
  - While high in LOAD_B/STREAM/FLUSH, state, index and all pe_* registers freeze, and pe_b_en is forced 0 during the stall.
  - A stall in FILL/DONE has no effect.
- Without the macro: port absent, sequence never pauses.

Decomposition:
- Shared package pe_pkg:
  - PE_DATA_W default constant.
  - Feeder state enum {FILL, LOAD_B, STREAM, FLUSH, DONE}.
  - Operand struct {a, b, b_en, psum} reused by future array feeders.
- One sub-module, pe_feeder_buf: DEPTH×DATA_W register file with write pointer/count and combinational read by index.
- FSM and output registers stay in the top.

Test Plan:
- Burst A=1,2 (s_last on 2), w_b=3, w_psum=3 → one cycle with pe_b=3, pe_b_en=1. Then pe_a=1 and pe_a=2, each with pe_psum=3. Then 2 zero cycles, then done pulse. s_ready=0 from got_last until done.
- w_valid arrives 5 cycles after s_last → feeder stays in FILL, no pe_b_en, until the edge after weight load. Sequence then matches the first test.
- 8 words without s_last (DEPTH=8) → s_ready drops after the 8th accept. STREAM emits exactly 8 A values in order.
- Upstream s_valid toggling 1,0,1,0 on A=5,7 → buffer holds 5,7 only; no duplicates or gaps in STREAM.
- rst raised mid-STREAM after pe_a=1 → pe_* go 0 immediately. After release, a new burst A=4, w_b=6 produces a clean LOAD_B (pe_b=6) and no residue of old data.
- (PE_FEEDER_STALL_EN) pe_stall high 3 cycles during STREAM at pe_a=2 → pe_a stays 2 for 3 extra cycles, then the sequence resumes. done is delayed by exactly 3 cycles.
